// File: rtl/cryptoveril_pkg.sv
// Shared definitions for the cryptoveril cipher core, its feeder and benches.
package cryptoveril_pkg;

   localparam int DATA_W = 16;
   localparam int KEY_W  = 5;

   // Feeder sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RUN     = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

endpackage

// File: rtl/cryptoveril_feeder_if.sv
// Plaintext input stream and ciphertext result stream of the feeder.
// The master side is the upstream producer / downstream consumer pair,
// the slave side is the feeder itself.
interface cryptoveril_feeder_if;
   import cryptoveril_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready;

   modport master (
      output in_data, in_valid, res_ready,
      input  in_ready, res_data, res_valid
   );

   modport slave (
      input  in_data, in_valid, res_ready,
      output in_ready, res_data, res_valid
   );

endinterface

// File: rtl/cryptoveril_fifo.sv
// Synchronous plaintext FIFO. DEPTH must be a power of two so the
// read/write pointers wrap on their own. Head word is readable without a pop.
module cryptoveril_fifo
   import cryptoveril_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [AW:0]       o_count,
   output logic              o_full,
   output logic              o_empty
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_do_push;
   logic              w_do_pop;

   // Requests are qualified here so a misbehaving caller cannot corrupt the count.
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == {(AW+1){1'b0}});

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk1) begin
      if (rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset because the count guards reads.
   always_ff @(posedge clk1) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

endmodule

// File: rtl/cryptoveril_feeder.sv
// Upstream sequencer for the cryptoveril core: queues plaintext words, keeps
// a key shadow, drives ld/start, waits a fixed latency and returns the
// sampled core output over a valid/ready port.
module cryptoveril_feeder
   import cryptoveril_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   parameter  int LATENCY    = 27,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk1,
   input  logic               rst,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               key_we,
   cryptoveril_feeder_if.slave bus,
   output logic [DATA_W-1:0]  cv_input_data,
   output logic [KEY_W-1:0]   cv_key_bits,
   output logic               cv_ld,
   output logic               cv_start,
   input  logic [DATA_W-1:0]  cv_output_data,
   output logic               busy,
   output logic [CNT_W-1:0]   fifo_count
);

   localparam int               CTR_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(LATENCY - 1);
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

   state_t            r_state;
   logic [CTR_W-1:0]  r_ctr;
   logic [KEY_W-1:0]  r_key;
   logic [DATA_W-1:0] r_cv_input_data;
   logic [KEY_W-1:0]  r_cv_key_bits;
   logic              r_cv_ld;
   logic              r_cv_start;
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_valid;
   logic              r_busy;

   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head;
   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_has_data;

   assign w_has_data = ~w_empty;
   // A full FIFO refuses a word even when a pop happens on the same edge.
   assign w_push     = bus.in_valid & ~w_full;

   cryptoveril_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk1    (clk1),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (bus.in_data),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Pop the head word when the sequencer is ready to start the next one.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         ST_IDLE:    w_pop = w_has_data;
         ST_CAPTURE: w_pop = bus.res_ready & w_has_data;
         default:    w_pop = 1'b0;
      endcase
   end

   // Key shadow; only copied to the core when a word is loaded.
   always_ff @(posedge clk1) begin
      if (rst) begin
         r_key <= {KEY_W{1'b0}};
      end else if (key_we) begin
         r_key <= key_in;
      end
   end

   // Sequencer FSM with registered core controls and result port.
   always_ff @(posedge clk1) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_ctr           <= {CTR_W{1'b0}};
         r_cv_input_data <= {DATA_W{1'b0}};
         r_cv_key_bits   <= {KEY_W{1'b0}};
         r_cv_ld         <= 1'b0;
         r_cv_start      <= 1'b0;
         r_res_data      <= {DATA_W{1'b0}};
         r_res_valid     <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_has_data) begin
                  r_cv_input_data <= w_head;
                  r_cv_key_bits   <= r_key;
                  r_cv_ld         <= 1'b1;
                  r_cv_start      <= 1'b1;
                  r_busy          <= 1'b1;
                  r_state         <= ST_LOAD;
               end else begin
                  r_cv_ld    <= 1'b0;
                  r_cv_start <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            ST_LOAD: begin
               r_cv_ld <= 1'b0;
               r_ctr   <= CTR_LOAD;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (r_ctr == {CTR_W{1'b0}}) begin
                  r_res_data  <= cv_output_data;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_CAPTURE;
               end else begin
                  r_ctr <= r_ctr - CTR_ONE;
               end
            end
            ST_CAPTURE: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  if (w_has_data) begin
                     // Chain straight into the next word without visiting IDLE.
                     r_cv_input_data <= w_head;
                     r_cv_key_bits   <= r_key;
                     r_cv_ld         <= 1'b1;
                     r_state         <= ST_LOAD;
                  end else begin
                     r_cv_start <= 1'b0;
                     r_busy     <= 1'b0;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cv_ld     <= 1'b0;
               r_cv_start  <= 1'b0;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cv_input_data = r_cv_input_data;
   assign cv_key_bits   = r_cv_key_bits;
   assign cv_ld         = r_cv_ld;
   assign cv_start      = r_cv_start;
   assign bus.res_data  = r_res_data;
   assign bus.res_valid = r_res_valid;
   assign busy          = r_busy;
   assign bus.in_ready  = ~w_full;
   assign fifo_count    = w_count;

endmodule

// File: tb/tb_cryptoveril_feeder.sv
// Self-checking bench for cryptoveril_feeder. The core is stubbed as
// output = input ^ 16'hA5A5; a queue-based reference model predicts outputs.
module tb_cryptoveril_feeder;

   localparam int DEPTH = 4;
   localparam int LAT   = 27;

   logic        clk1 = 1'b0;
   logic        rst;
   logic [4:0]  key_in;
   logic        key_we;
   logic [15:0] cv_input_data;
   logic [4:0]  cv_key_bits;
   logic        cv_ld;
   logic        cv_start;
   logic [15:0] cv_output_data;
   logic        busy;
   logic [2:0]  fifo_count;

   int n_checks = 0;
   int n_errors = 0;

   cryptoveril_feeder_if u_bus ();

   cryptoveril_feeder #(
      .FIFO_DEPTH (DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clk1           (clk1),
      .rst            (rst),
      .key_in         (key_in),
      .key_we         (key_we),
      .bus            (u_bus),
      .cv_input_data  (cv_input_data),
      .cv_key_bits    (cv_key_bits),
      .cv_ld          (cv_ld),
      .cv_start       (cv_start),
      .cv_output_data (cv_output_data),
      .busy           (busy),
      .fifo_count     (fifo_count)
   );

   assign cv_output_data = cv_input_data ^ 16'hA5A5;

   always #5 clk1 = ~clk1;

   // ---------------- reference model ----------------
   logic [15:0] mq[$];
   int          m_e = 0;
   int          m_count = 0;
   bit          m_active = 1'b0;
   bit          m_rvalid = 1'b0;
   int          m_L = -1;
   int          m_V = -1;
   logic [15:0] m_din = 16'h0;
   logic [4:0]  m_keyout = 5'h0;
   logic [4:0]  m_shadow = 5'h0;
   logic [15:0] m_rdata = 16'h0;

   task automatic model_edge();
      int c0;
      m_e++;
      if (rst) begin
         mq.delete();
         m_count = 0; m_active = 1'b0; m_rvalid = 1'b0;
         m_L = -1; m_V = -1;
         m_din = 16'h0; m_keyout = 5'h0; m_shadow = 5'h0; m_rdata = 16'h0;
      end else begin
         c0 = m_count;
         if (m_active && m_rvalid && u_bus.res_ready) begin
            m_active = 1'b0;
            m_rvalid = 1'b0;
         end
         if (!m_active && mq.size() > 0) begin
            m_din    = mq.pop_front();
            m_keyout = m_shadow;
            m_active = 1'b1;
            m_L      = m_e;
            m_V      = m_e + 1 + LAT;
            m_count--;
         end
         if (m_active && !m_rvalid && m_e == m_V) begin
            m_rvalid = 1'b1;
            m_rdata  = m_din ^ 16'hA5A5;
         end
         if (u_bus.in_valid && c0 < DEPTH) begin
            mq.push_back(u_bus.in_data);
            m_count++;
         end
         if (key_we) m_shadow = key_in;
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      model_edge();
      @(negedge clk1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; key_in = 5'h0; key_we = 1'b0;
      u_bus.in_valid = 1'b0; u_bus.in_data = 16'h0; u_bus.res_ready = 1'b0;
      repeat (5) tick();
      n_checks++; if (cv_input_data !== 16'h0) begin n_errors++; $display("FAIL reset_cv_input_data: got %h want 0000", cv_input_data); end
      n_checks++; if (cv_key_bits !== 5'h0) begin n_errors++; $display("FAIL reset_cv_key_bits: got %h want 00", cv_key_bits); end
      n_checks++; if (cv_ld !== 1'b0) begin n_errors++; $display("FAIL reset_cv_ld: got %b want 0", cv_ld); end
      n_checks++; if (cv_start !== 1'b0) begin n_errors++; $display("FAIL reset_cv_start: got %b want 0", cv_start); end
      n_checks++; if (u_bus.res_data !== 16'h0) begin n_errors++; $display("FAIL reset_res_data: got %h want 0000", u_bus.res_data); end
      n_checks++; if (u_bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b want 0", u_bus.res_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
      n_checks++; if (u_bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", u_bus.in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single_word();
      int ld_cnt = 0;
      int ld_k = -1;
      int rise_k = -1;
      logic [15:0] ld_data = 16'hxxxx;
      logic [4:0]  ld_key = 5'hxx;
      logic [15:0] rdat = 16'hxxxx;
      bit start_ok = 1'b1;
      u_bus.res_ready = 1'b1;
      key_in = 5'b00110; key_we = 1'b1; tick(); key_we = 1'b0;
      u_bus.in_data = 16'h0001; u_bus.in_valid = 1'b1;
      n_checks++; if (u_bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL single_in_ready: got %b want 1", u_bus.in_ready); end
      tick();
      u_bus.in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (cv_ld === 1'b1) begin
            ld_cnt++;
            if (ld_k < 0) begin ld_k = k; ld_data = cv_input_data; ld_key = cv_key_bits; end
         end
         if (u_bus.res_valid === 1'b1 && rise_k < 0) begin rise_k = k; rdat = u_bus.res_data; end
         if (k <= LAT + 2 && cv_start !== 1'b1) start_ok = 1'b0;
      end
      n_checks++; if (ld_cnt != 1) begin n_errors++; $display("FAIL single_ld_pulses: got %0d want 1", ld_cnt); end
      n_checks++; if (ld_k != 1) begin n_errors++; $display("FAIL single_ld_cycle: got %0d want 1", ld_k); end
      n_checks++; if (ld_data !== 16'h0001) begin n_errors++; $display("FAIL single_ld_data: got %h want 0001", ld_data); end
      n_checks++; if (ld_key !== 5'd6) begin n_errors++; $display("FAIL single_ld_key: got %0d want 6", ld_key); end
      n_checks++; if (rise_k != LAT + 2) begin n_errors++; $display("FAIL single_latency: got %0d want %0d", rise_k, LAT + 2); end
      n_checks++; if (rdat !== 16'hA5A4) begin n_errors++; $display("FAIL single_res_data: got %h want a5a4", rdat); end
      n_checks++; if (!start_ok) begin n_errors++; $display("FAIL single_cv_start: got gap want 1 throughout"); end
      n_checks++; if (busy !== 1'b0 || u_bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL single_idle_after: got busy=%b valid=%b want 0 0", busy, u_bus.res_valid); end
   endtask

   task automatic test_fill();
      logic [15:0] got[$];
      int rise[$];
      int next = 1;
      int cyc = 0;
      bit saw_full = 1'b0;
      bit accepted;
      logic prev_v;
      u_bus.res_ready = 1'b1;
      prev_v = u_bus.res_valid;
      while (got.size() < 6 && cyc < 400) begin
         accepted = 1'b0;
         if (next <= 6) begin
            u_bus.in_valid = 1'b1;
            u_bus.in_data  = 16'(next);
            n_checks++;
            if (u_bus.in_ready !== (m_count < DEPTH)) begin
               n_errors++; $display("FAIL fill_in_ready: got %b want %b", u_bus.in_ready, (m_count < DEPTH));
            end
            if (u_bus.in_ready === 1'b0) saw_full = 1'b1;
            accepted = (u_bus.in_ready === 1'b1);
         end else begin
            u_bus.in_valid = 1'b0;
         end
         tick(); cyc++;
         if (accepted) next++;
         if (u_bus.res_valid === 1'b1 && prev_v !== 1'b1) begin
            got.push_back(u_bus.res_data);
            rise.push_back(cyc);
         end
         prev_v = u_bus.res_valid;
      end
      u_bus.in_valid = 1'b0;
      n_checks++; if (got.size() != 6) begin n_errors++; $display("FAIL fill_timeout: got %0d results want 6", got.size()); end
      n_checks++; if (!saw_full) begin n_errors++; $display("FAIL fill_backpressure: got in_ready never low want low once full"); end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== (16'(i + 1) ^ 16'hA5A5)) begin
            n_errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, got[i], 16'(i + 1) ^ 16'hA5A5);
         end
         if (i > 0) begin
            n_checks++;
            if (rise[i] - rise[i-1] != LAT + 2) begin
               n_errors++; $display("FAIL fill_spacing[%0d]: got %0d want %0d", i, rise[i] - rise[i-1], LAT + 2);
            end
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_backpressure();
      int cyc;
      bit stable = 1'b1;
      bit no_ld = 1'b1;
      logic [15:0] hold_data;
      u_bus.res_ready = 1'b0;
      u_bus.in_valid = 1'b1; u_bus.in_data = 16'h1234; tick();
      u_bus.in_data = 16'h5678; tick();
      u_bus.in_valid = 1'b0;
      for (cyc = 0; cyc < 60 && u_bus.res_valid !== 1'b1; cyc++) tick();
      n_checks++; if (u_bus.res_valid !== 1'b1) begin n_errors++; $display("FAIL bp_first_result: got valid=%b want 1", u_bus.res_valid); end
      hold_data = 16'h1234 ^ 16'hA5A5;
      repeat (10) begin
         tick();
         if (u_bus.res_valid !== 1'b1 || u_bus.res_data !== hold_data) stable = 1'b0;
         if (cv_ld !== 1'b0) no_ld = 1'b0;
      end
      n_checks++; if (!stable) begin n_errors++; $display("FAIL bp_stable: got changing result want %h held", hold_data); end
      n_checks++; if (!no_ld) begin n_errors++; $display("FAIL bp_no_load: got cv_ld during stall want 0"); end
      n_checks++; if (fifo_count !== 3'd1) begin n_errors++; $display("FAIL bp_queued: got %0d want 1", fifo_count); end
      u_bus.res_ready = 1'b1;
      tick();
      n_checks++; if (cv_ld !== 1'b1) begin n_errors++; $display("FAIL bp_release_ld: got %b want 1", cv_ld); end
      n_checks++; if (cv_input_data !== 16'h5678) begin n_errors++; $display("FAIL bp_release_data: got %h want 5678", cv_input_data); end
      n_checks++; if (u_bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid: got %b want 0", u_bus.res_valid); end
      for (cyc = 0; cyc < 40 && u_bus.res_valid !== 1'b1; cyc++) tick();
      n_checks++; if (u_bus.res_valid !== 1'b1 || u_bus.res_data !== (16'h5678 ^ 16'hA5A5)) begin
         n_errors++; $display("FAIL bp_second_result: got valid=%b data=%h want 1 %h", u_bus.res_valid, u_bus.res_data, 16'h5678 ^ 16'hA5A5);
      end
      repeat (3) tick();
   endtask

   task automatic test_key_change();
      int cyc;
      bit key_held = 1'b1;
      u_bus.res_ready = 1'b1;
      key_in = 5'd6; key_we = 1'b1; tick(); key_we = 1'b0;
      u_bus.in_valid = 1'b1; u_bus.in_data = 16'h00AA; tick();
      u_bus.in_data = 16'h00BB; tick();
      u_bus.in_valid = 1'b0;
      n_checks++; if (cv_ld !== 1'b1 || cv_input_data !== 16'h00AA || cv_key_bits !== 5'd6) begin
         n_errors++; $display("FAIL key_first_load: got ld=%b data=%h key=%0d want 1 00aa 6", cv_ld, cv_input_data, cv_key_bits);
      end
      repeat (5) tick();
      key_in = 5'b11111; key_we = 1'b1; tick(); key_we = 1'b0;
      for (cyc = 0; cyc < 60 && cv_ld !== 1'b1; cyc++) begin
         if (cv_key_bits !== 5'd6) key_held = 1'b0;
         tick();
      end
      n_checks++; if (!key_held) begin n_errors++; $display("FAIL key_in_flight: got change during RUN want 6 held"); end
      n_checks++; if (cv_ld !== 1'b1 || cv_key_bits !== 5'd31 || cv_input_data !== 16'h00BB) begin
         n_errors++; $display("FAIL key_next_load: got ld=%b key=%0d data=%h want 1 31 00bb", cv_ld, cv_key_bits, cv_input_data);
      end
      repeat (35) tick();
   endtask

   task automatic test_reset_mid_run();
      bit quiet = 1'b1;
      u_bus.res_ready = 1'b1;
      u_bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         u_bus.in_data = 16'hC000 + 16'(i);
         tick();
      end
      u_bus.in_valid = 1'b0;
      repeat (5) tick();
      n_checks++; if (fifo_count !== 3'd2 || busy !== 1'b1) begin n_errors++; $display("FAIL rstrun_pre: got count=%0d busy=%b want 2 1", fifo_count, busy); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (cv_input_data !== 16'h0 || cv_key_bits !== 5'h0 || cv_ld !== 1'b0 || cv_start !== 1'b0) begin
         n_errors++; $display("FAIL rstrun_cv: got data=%h key=%h ld=%b start=%b want 0 0 0 0", cv_input_data, cv_key_bits, cv_ld, cv_start);
      end
      n_checks++; if (u_bus.res_data !== 16'h0 || u_bus.res_valid !== 1'b0) begin
         n_errors++; $display("FAIL rstrun_res: got data=%h valid=%b want 0 0", u_bus.res_data, u_bus.res_valid);
      end
      n_checks++; if (fifo_count !== 3'd0 || busy !== 1'b0 || u_bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL rstrun_state: got count=%0d busy=%b ready=%b want 0 0 1", fifo_count, busy, u_bus.in_ready);
      end
      repeat (80) begin
         tick();
         if (u_bus.res_valid !== 1'b0 || cv_ld !== 1'b0) quiet = 1'b0;
      end
      n_checks++; if (!quiet) begin n_errors++; $display("FAIL rstrun_dropped: got activity after reset want none"); end
   endtask

   task automatic test_random();
      bit heavy;
      logic [2:0] exp_cnt;
      for (int i = 0; i < 1600; i++) begin
         heavy = (i < 900);
         u_bus.in_valid  = ($urandom_range(99) < (heavy ? 70 : 4));
         u_bus.in_data   = 16'($urandom);
         u_bus.res_ready = ($urandom_range(99) < (heavy ? 55 : 85));
         key_we = ($urandom_range(99) < 6);
         key_in = 5'($urandom);
         tick();
         exp_cnt = 3'(m_count);
         n_checks++; if (fifo_count !== exp_cnt) begin n_errors++; $display("FAIL rand_fifo_count @%0d: got %0d want %0d", i, fifo_count, exp_cnt); end
         n_checks++; if (u_bus.in_ready !== (m_count < DEPTH)) begin n_errors++; $display("FAIL rand_in_ready @%0d: got %b want %b", i, u_bus.in_ready, (m_count < DEPTH)); end
         n_checks++; if (busy !== m_active) begin n_errors++; $display("FAIL rand_busy @%0d: got %b want %b", i, busy, m_active); end
         n_checks++; if (cv_start !== m_active) begin n_errors++; $display("FAIL rand_cv_start @%0d: got %b want %b", i, cv_start, m_active); end
         n_checks++; if (cv_ld !== (m_L == m_e)) begin n_errors++; $display("FAIL rand_cv_ld @%0d: got %b want %b", i, cv_ld, (m_L == m_e)); end
         n_checks++; if (cv_input_data !== m_din) begin n_errors++; $display("FAIL rand_cv_input_data @%0d: got %h want %h", i, cv_input_data, m_din); end
         n_checks++; if (cv_key_bits !== m_keyout) begin n_errors++; $display("FAIL rand_cv_key_bits @%0d: got %h want %h", i, cv_key_bits, m_keyout); end
         n_checks++; if (u_bus.res_valid !== m_rvalid) begin n_errors++; $display("FAIL rand_res_valid @%0d: got %b want %b", i, u_bus.res_valid, m_rvalid); end
         n_checks++; if (u_bus.res_data !== m_rdata) begin n_errors++; $display("FAIL rand_res_data @%0d: got %h want %h", i, u_bus.res_data, m_rdata); end
         if (n_errors > 40) break;
      end
      u_bus.in_valid = 1'b0;
      key_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      key_in = 5'h0;
      key_we = 1'b0;
      u_bus.in_valid = 1'b0;
      u_bus.in_data = 16'h0;
      u_bus.res_ready = 1'b0;
      test_reset();
      test_single_word();
      test_fill();
      test_backpressure();
      test_key_change();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
